// File: rtl/clock_time_setter.sv
// Time-entry front end for the HH:MM:SS clock: conditions the set switch and keys,
// then runs the capture/edit/commit FSM that produces the Load strobe and blink mask.
module clock_time_setter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000,
    parameter int HOUR_MAX        = 23
) (
    input  logic        CLK_50_MHZ_GEN,
    input  logic        Reset,
    input  logic        Time_Set,
    input  logic        Key_Sel_n,
    input  logic        Key_Inc_n,
    input  logic [23:0] Cur_Time,
    output logic [23:0] Set_Time,
    output logic        Load,
    output logic        Edit_Active,
    output logic [5:0]  Blink_Mask
);

    localparam int DbWidth    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BlinkWidth = $clog2(BLINK_CYCLES + 1);
    localparam logic [DbWidth-1:0]    DbLast     = DbWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [BlinkWidth-1:0] BlinkLast  = BlinkWidth'(BLINK_CYCLES - 1);
    localparam logic [7:0]            HourMaxBcd = 8'(((HOUR_MAX / 10) << 4) + (HOUR_MAX % 10));
    // Bit 0 is the set switch (idle low), bits 1/2 are the active-low keys (idle high).
    localparam logic [2:0]            IdleLevels = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } stateT;

    stateT                 state;
    stateT                 nextState;
    logic [2:0]            rawIn;
    logic [2:0]            sync1;
    logic [2:0]            sync2;
    logic [2:0]            dbLevel;
    logic [2:0]            dbNext;
    logic [DbWidth-1:0]    dbCount [3];
    logic                  setRise;
    logic                  selPress;
    logic                  incPress;
    logic [23:0]           nextSetTime;
    logic                  blinkRestart;
    logic [BlinkWidth-1:0] blinkCount;
    logic                  blinkPhase;

    assign rawIn = {Key_Inc_n, Key_Sel_n, Time_Set};

    // Wraps to 00 at the field maximum, and also clears any invalid BCD value.
    function automatic logic [7:0] bcdInc(input logic [7:0] field, input logic [7:0] maxVal);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = field[7:4];
        ones = field[3:0];
        if (tens > 4'd9 || ones > 4'd9 || field >= maxVal) begin
            return 8'h00;
        end
        if (ones == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, ones + 4'd1};
    endfunction

    always_comb begin
        dbNext = dbLevel;
        for (int i = 0; i < 3; i++) begin
            if (sync2[i] != dbLevel[i] && dbCount[i] == DbLast) begin
                dbNext[i] = sync2[i];
            end
        end
    end

    // Events are registered alongside the new debounced level so both are seen in the same cycle.
    always_ff @(posedge CLK_50_MHZ_GEN or posedge Reset) begin
        if (Reset) begin
            sync1    <= IdleLevels;
            sync2    <= IdleLevels;
            dbLevel  <= IdleLevels;
            setRise  <= 1'b0;
            selPress <= 1'b0;
            incPress <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                dbCount[i] <= '0;
            end
        end else begin
            sync1    <= rawIn;
            sync2    <= sync1;
            dbLevel  <= dbNext;
            setRise  <= ~dbLevel[0] & dbNext[0];
            selPress <= dbLevel[1] & ~dbNext[1];
            incPress <= dbLevel[2] & ~dbNext[2];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == dbLevel[i] || dbCount[i] == DbLast) begin
                    dbCount[i] <= '0;
                end else begin
                    dbCount[i] <= dbCount[i] + DbWidth'(1);
                end
            end
        end
    end

    // Dropping the set switch wins over any key event arriving in the same cycle.
    always_comb begin
        nextState    = state;
        nextSetTime  = Set_Time;
        blinkRestart = 1'b0;
        unique case (state)
            IDLE: begin
                if (setRise) begin
                    nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                nextSetTime = Cur_Time;
                nextState   = EDIT_HR;
            end
            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                if (!dbLevel[0]) begin
                    nextState = COMMIT;
                end else begin
                    if (incPress) begin
                        unique case (state)
                            EDIT_HR:  nextSetTime[23:16] = bcdInc(Set_Time[23:16], HourMaxBcd);
                            EDIT_MIN: nextSetTime[15:8]  = bcdInc(Set_Time[15:8], 8'h59);
                            default:  nextSetTime[7:0]   = bcdInc(Set_Time[7:0], 8'h59);
                        endcase
                    end
                    if (selPress) begin
                        blinkRestart = 1'b1;
                        unique case (state)
                            EDIT_HR:  nextState = EDIT_MIN;
                            EDIT_MIN: nextState = EDIT_SEC;
                            default:  nextState = EDIT_HR;
                        endcase
                    end
                end
            end
            COMMIT: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50_MHZ_GEN or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            Set_Time    <= '0;
            Load        <= 1'b0;
            Edit_Active <= 1'b0;
            blinkCount  <= '0;
            blinkPhase  <= 1'b0;
        end else begin
            state       <= nextState;
            Set_Time    <= nextSetTime;
            Load        <= (nextState == COMMIT);
            Edit_Active <= (nextState != IDLE);
            if (state == CAPTURE || blinkRestart) begin
                blinkCount <= '0;
                blinkPhase <= 1'b0;
            end else if (blinkCount == BlinkLast) begin
                blinkCount <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                blinkCount <= blinkCount + BlinkWidth'(1);
            end
        end
    end

    always_comb begin
        Blink_Mask = '0;
        unique case (state)
            EDIT_HR:  Blink_Mask = {{2{blinkPhase}}, 4'b0000};
            EDIT_MIN: Blink_Mask = {2'b00, {2{blinkPhase}}, 2'b00};
            EDIT_SEC: Blink_Mask = {4'b0000, {2{blinkPhase}}};
            default:  Blink_Mask = '0;
        endcase
    end

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed scenarios plus randomized edit sessions
// checked against a decimal field model of the time editor.
module tb_clock_time_setter;

    localparam int DEB    = 4;
    localparam int BLINK  = 8;
    localparam int HMAX   = 23;
    localparam int SETTLE = DEB + 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        timeSet = 1'b0;
    logic        keySelN = 1'b1;
    logic        keyIncN = 1'b1;
    logic [23:0] curTime = '0;
    logic [23:0] setTime;
    logic        load;
    logic        editActive;
    logic [5:0]  blinkMask;

    int compared = 0;
    int mismatched = 0;
    int loadsSeen = 0;
    int loadsExpected = 0;

    logic [7:0] field [3];
    int         selIdx = 0;

    always #5 clock = ~clock;

    clock_time_setter #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLINK),
        .HOUR_MAX       (HMAX)
    ) dut (
        .CLK_50_MHZ_GEN(clock),
        .Reset         (reset),
        .Time_Set      (timeSet),
        .Key_Sel_n     (keySelN),
        .Key_Inc_n     (keyIncN),
        .Cur_Time      (curTime),
        .Set_Time      (setTime),
        .Load          (load),
        .Edit_Active   (editActive),
        .Blink_Mask    (blinkMask)
    );

    always @(negedge clock) begin
        if (load === 1'b1) loadsSeen++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int bcdToDec(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 99;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] decToBcd(input int d);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(d / 10);
        o = 4'(d % 10);
        return {t, o};
    endfunction

    function automatic void modelCapture(input logic [23:0] t);
        field[0] = t[23:16];
        field[1] = t[15:8];
        field[2] = t[7:0];
        selIdx   = 0;
    endfunction

    function automatic void modelInc();
        int d;
        int maxVal;
        maxVal = (selIdx == 0) ? HMAX : 59;
        d = bcdToDec(field[selIdx]);
        field[selIdx] = (d >= maxVal) ? 8'h00 : decToBcd(d + 1);
    endfunction

    function automatic logic [23:0] modelTime();
        return {field[0], field[1], field[2]};
    endfunction

    function automatic logic [5:0] modelMask();
        return 6'b110000 >> (2 * selIdx);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pressKeys(input bit sel, input bit inc);
        if (sel) keySelN = 1'b0;
        if (inc) keyIncN = 1'b0;
        tick(SETTLE);
        keySelN = 1'b1;
        keyIncN = 1'b1;
        tick(SETTLE);
        if (inc) modelInc();
        if (sel) selIdx = (selIdx + 1) % 3;
    endtask

    task automatic enterEdit(input logic [23:0] t, output bit ok, output int cycles);
        curTime = t;
        timeSet = 1'b1;
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            cycles++;
            if (editActive === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick(2);
        modelCapture(t);
    endtask

    task automatic sampleBlink(input logic [5:0] pat, output bit sawOn, output bit sawOff, output bit sawBad);
        sawOn = 1'b0;
        sawOff = 1'b0;
        sawBad = 1'b0;
        for (int i = 0; i < 2 * BLINK + 4; i++) begin
            tick(1);
            if (blinkMask === pat) sawOn = 1'b1;
            else if (blinkMask === 6'b0) sawOff = 1'b0 | 1'b1;
            else sawBad = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        tick(3);
        compared++;
        if ({setTime, load, editActive, blinkMask} !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", {setTime, load, editActive, blinkMask}, 32'h0);
        end
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if ({setTime, load, editActive, blinkMask} !== 32'h0) bad = 1'b1;
        end
        compared++;
        if (bad) begin
            mismatched++;
            $display("[TB] FAIL idle_quiet: got %h expected %h", {setTime, load, editActive, blinkMask}, 32'h0);
        end
    endtask

    task automatic test_capture();
        bit ok;
        int cycles;
        bit sawOn, sawOff, sawBad;
        enterEdit(24'h235958, ok, cycles);
        compared++;
        if (!ok || cycles < 5 || cycles > 9) begin
            mismatched++;
            $display("[TB] FAIL capture_latency: got %0d cycles (ok=%0d) expected 5..9", cycles, ok);
        end
        curTime = 24'h121212;
        compared++;
        if (setTime !== 24'h235958) begin
            mismatched++;
            $display("[TB] FAIL capture_value: got %h expected %h", setTime, 24'h235958);
        end
        sampleBlink(6'b110000, sawOn, sawOff, sawBad);
        compared++;
        if (!(sawOn && sawOff && !sawBad)) begin
            mismatched++;
            $display("[TB] FAIL blink_hours: got mask %b expected toggling %b", blinkMask, 6'b110000);
        end
        pressKeys(1'b0, 1'b1);
        compared++;
        if (setTime !== 24'h005958 || modelTime() !== 24'h005958) begin
            mismatched++;
            $display("[TB] FAIL hour_wrap: got %h expected %h", setTime, 24'h005958);
        end
    endtask

    task automatic test_sel_inc();
        bit sawOn, sawOff, sawBad;
        pressKeys(1'b1, 1'b0);
        pressKeys(1'b0, 1'b1);
        pressKeys(1'b0, 1'b1);
        compared++;
        if (setTime !== 24'h000158) begin
            mismatched++;
            $display("[TB] FAIL minute_wrap: got %h expected %h", setTime, 24'h000158);
        end
        sampleBlink(6'b001100, sawOn, sawOff, sawBad);
        compared++;
        if (!(sawOn && sawOff && !sawBad)) begin
            mismatched++;
            $display("[TB] FAIL blink_minutes: got mask %b expected toggling %b", blinkMask, 6'b001100);
        end
        pressKeys(1'b1, 1'b0);
        pressKeys(1'b1, 1'b0);
        sampleBlink(6'b110000, sawOn, sawOff, sawBad);
        compared++;
        if (!(sawOn && sawOff && !sawBad)) begin
            mismatched++;
            $display("[TB] FAIL blink_wrap_sel: got mask %b expected toggling %b", blinkMask, 6'b110000);
        end
    endtask

    task automatic test_debounce();
        keyIncN = 1'b0;
        tick(2);
        keyIncN = 1'b1;
        tick(SETTLE + 4);
        compared++;
        if (setTime !== modelTime()) begin
            mismatched++;
            $display("[TB] FAIL short_pulse: got %h expected %h", setTime, modelTime());
        end
        for (int i = 0; i < 3; i++) begin
            keyIncN = 1'b0;
            tick(1);
            keyIncN = 1'b1;
            tick(1);
        end
        keyIncN = 1'b0;
        tick(5 * DEB);
        keyIncN = 1'b1;
        tick(SETTLE);
        modelInc();
        compared++;
        if (setTime !== modelTime()) begin
            mismatched++;
            $display("[TB] FAIL bounce_single_inc: got %h expected %h", setTime, modelTime());
        end
    endtask

    task automatic test_commit();
        logic        loadArr [40];
        logic        editArr [40];
        logic [23:0] timeArr [40];
        int          loads;
        int          at;
        timeSet = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            loadArr[i] = load;
            editArr[i] = editActive;
            timeArr[i] = setTime;
        end
        loads = 0;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            if (loadArr[i] === 1'b1) begin
                loads++;
                if (at < 0) at = i;
            end
        end
        loadsExpected++;
        compared++;
        if (loads != 1) begin
            mismatched++;
            $display("[TB] FAIL commit_load_count: got %0d expected %0d", loads, 1);
        end
        if (at >= 0 && at < 39) begin
            compared++;
            if (timeArr[at] !== modelTime()) begin
                mismatched++;
                $display("[TB] FAIL commit_value: got %h expected %h", timeArr[at], modelTime());
            end
            compared++;
            if (editArr[at + 1] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL commit_edit_drop: got %b expected %b", editArr[at + 1], 1'b0);
            end
        end
        compared++;
        if (blinkMask !== 6'b0 || setTime !== modelTime()) begin
            mismatched++;
            $display("[TB] FAIL idle_hold: got mask %b time %h expected mask %b time %h", blinkMask, setTime, 6'b0, modelTime());
        end
    endtask

    task automatic test_random();
        bit          ok;
        int          cycles;
        int          op;
        int          loads;
        logic [23:0] t;
        logic [23:0] loaded;
        bit          sawOn, sawOff, sawBad;
        for (int round = 0; round < 3; round++) begin
            if (round == 0) begin
                t = 24'($urandom);
            end else begin
                t = {decToBcd(int'($urandom_range(0, 23))), decToBcd(int'($urandom_range(0, 59))),
                     decToBcd(int'($urandom_range(0, 59)))};
            end
            enterEdit(t, ok, cycles);
            curTime = 24'($urandom);
            compared++;
            if (!ok || setTime !== modelTime()) begin
                mismatched++;
                $display("[TB] FAIL rand_capture: got %h expected %h", setTime, modelTime());
            end
            for (int k = 0; k < 8; k++) begin
                op = int'($urandom_range(0, 2));
                pressKeys(op != 1, op != 0);
                compared++;
                if (setTime !== modelTime()) begin
                    mismatched++;
                    $display("[TB] FAIL rand_op%0d: got %h expected %h", op, setTime, modelTime());
                end
                sampleBlink(modelMask(), sawOn, sawOff, sawBad);
                compared++;
                if (!(sawOn && sawOff && !sawBad)) begin
                    mismatched++;
                    $display("[TB] FAIL rand_blink: got mask %b expected toggling %b", blinkMask, modelMask());
                end
            end
            timeSet = 1'b0;
            loads = 0;
            loaded = 'x;
            for (int i = 0; i < 30; i++) begin
                tick(1);
                if (load === 1'b1) begin
                    loads++;
                    loaded = setTime;
                end
            end
            loadsExpected++;
            compared++;
            if (loads != 1 || loaded !== modelTime()) begin
                mismatched++;
                $display("[TB] FAIL rand_commit: got %0d loads value %h expected 1 load value %h", loads, loaded, modelTime());
            end
        end
    endtask

    task automatic test_reset_mid_edit();
        bit ok;
        int cycles;
        enterEdit(24'h104527, ok, cycles);
        pressKeys(1'b0, 1'b1);
        reset = 1'b1;
        #1;
        compared++;
        if (editActive !== 1'b0 || setTime !== 24'h0 || load !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_edit: got edit %b time %h load %b expected 0 000000 0", editActive, setTime, load);
        end
        tick(3);
        reset = 1'b0;
        curTime = 24'h071503;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (editActive === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick(2);
        compared++;
        if (!ok || setTime !== 24'h071503) begin
            mismatched++;
            $display("[TB] FAIL reset_recapture: got %h (edit=%0d) expected %h", setTime, ok, 24'h071503);
        end
        timeSet = 1'b0;
        tick(30);
        loadsExpected++;
    endtask

    task automatic test_load_count();
        compared++;
        if (loadsSeen != loadsExpected) begin
            mismatched++;
            $display("[TB] FAIL total_loads: got %0d expected %0d", loadsSeen, loadsExpected);
        end
    endtask

    initial begin
        field[0] = '0;
        field[1] = '0;
        field[2] = '0;
        test_reset();
        test_capture();
        test_sel_inc();
        test_debounce();
        test_commit();
        test_random();
        test_reset_mid_edit();
        test_load_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
